// File: rtl/ctrl_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : ctrl_seq_pkg                                                 |
// | Purpose : Shared types and constants for the ctrl_seq sequencer:       |
// |           instruction width, opcode and FSM-state enums, HALT word.    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package ctrl_seq_pkg;

  localparam int INSTR_W = 9;

  // Instruction word: [8:6] op, [5:3] rs, [2:0] rt
  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_AND   = 3'b001,
    OP_XOR   = 3'b010,
    OP_BEQ   = 3'b011,
    OP_MOVE  = 3'b100,
    OP_LOAD  = 3'b101,
    OP_STORE = 3'b110,
    OP_RTL   = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4
  } state_t;

  // All-ones word is reserved as HALT even though its op field reads as rtl
  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'b111_111_111;

endpackage
`default_nettype wire

// File: rtl/ctrl_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : ctrl_seq_if                                                |
// | Purpose   : Bundles the sequencer's instruction-memory, regfile, ALU   |
// |             and data-memory signals.                                   |
// | Signals   : imem_addr/imem_rdata  instruction fetch                    |
// |             alu_cmd/alu_zero      ALU opcode and zero flag             |
// |             rf_ra_a/rf_ra_b/rf_wa/rf_we/rf_wsel  regfile control       |
// |             dmem_req/dmem_we/dmem_ack  data-memory handshake           |
// | Modports  : master = sequencer side, slave = datapath/memory side      |
// | Rev       : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface ctrl_seq_if #(
  parameter int PC_W = 10
);
  import ctrl_seq_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [2:0]         alu_cmd;
  logic [2:0]         rf_ra_a;
  logic [2:0]         rf_ra_b;
  logic [2:0]         rf_wa;
  logic               rf_we;
  logic               rf_wsel;
  logic               alu_zero;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ack;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output alu_cmd,
    output rf_ra_a,
    output rf_ra_b,
    output rf_wa,
    output rf_we,
    output rf_wsel,
    input  alu_zero,
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  alu_cmd,
    input  rf_ra_a,
    input  rf_ra_b,
    input  rf_wa,
    input  rf_we,
    input  rf_wsel,
    output alu_zero,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );

endinterface
`default_nettype wire

// File: rtl/ctrl_seq_branch_lut.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ctrl_seq_branch_lut                                          |
// | Purpose : Constant branch-target table indexed by the rt field of beq. |
// | Ports   : idx_i    (3)    table index                                  |
// |           target_o (PC_W) branch target PC                             |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ctrl_seq_branch_lut #(
  parameter int PC_W = 10
) (
  input  logic [2:0]      idx_i,
  output logic [PC_W-1:0] target_o
);

  logic [9:0] raw;

  // Targets are written for a 10-bit PC and resized to the actual PC width
  always_comb begin
    raw = 10'h000;
    case (idx_i)
      3'd0:    raw = 10'h000;
      3'd1:    raw = 10'h010;
      3'd2:    raw = 10'h020;
      3'd3:    raw = 10'h040;
      3'd4:    raw = 10'h080;
      3'd5:    raw = 10'h100;
      3'd6:    raw = 10'h200;
      default: raw = 10'h3FF;
    endcase
    target_o = PC_W'(raw);
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ctrl_seq                                                     |
// | Purpose : Multi-cycle control sequencer for the 8-bit datapath.        |
// |           Fetches and decodes 9-bit instructions, drives ALU/regfile   |
// |           controls, resolves beq from alu_zero, and runs loads/stores  |
// |           over a req/ack data-memory handshake.                        |
// | Ports   : clk, reset  clock and synchronous active-high reset          |
// |           start       begin execution at START_PC (IDLE only)          |
// |           busy        high whenever not IDLE                           |
// |           done        one-cycle pulse as HALT retires                  |
// |           bus         ctrl_seq_if.master (imem, regfile, ALU, dmem)    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  ctrl_seq_if.master   bus
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  op_t             op;
  logic [2:0]      rs;
  logic [2:0]      rt;
  logic            is_halt;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_inc;

  assign op      = op_t'(ir_q[8:6]);
  assign rs      = ir_q[5:3];
  assign rt      = ir_q[2:0];
  assign is_halt = (ir_q == HALT_INSTR);
  assign pc_inc  = pc_q + PC_W'(1);   // wraps silently at the top of memory

  ctrl_seq_branch_lut #(
    .PC_W (PC_W)
  ) u_branch_lut (
    .idx_i    (rt),
    .target_o (br_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= START_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    busy         = (state_q != ST_IDLE);
    done         = 1'b0;
    bus.imem_addr = pc_q;
    bus.alu_cmd  = 3'd0;
    bus.rf_ra_a  = 3'd0;
    bus.rf_ra_b  = 3'd0;
    bus.rf_wa    = 3'd0;
    bus.rf_we    = 1'b0;
    bus.rf_wsel  = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;

    // Operand/opcode drive is held through MEM so the ALU keeps producing
    // the data-memory address and store data until the ack arrives.
    if (state_q == ST_EXEC || state_q == ST_MEM) begin
      bus.alu_cmd = op;
      bus.rf_ra_a = rs;
      bus.rf_ra_b = (op == OP_BEQ) ? 3'd0 : rt;
      bus.rf_wa   = rs;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = START_PC;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d    = bus.imem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_halt) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          case (op)
            OP_BEQ: begin
              pc_d    = bus.alu_zero ? br_target : pc_inc;
              state_d = ST_FETCH;
            end
            OP_LOAD, OP_STORE: begin
              state_d = ST_MEM;
            end
            default: begin
              bus.rf_we = 1'b1;
              pc_d      = pc_inc;
              state_d   = ST_FETCH;
            end
          endcase
        end
      end
      ST_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (op == OP_STORE);
        bus.rf_wsel  = (op == OP_LOAD);
        if (bus.dmem_ack) begin
          bus.rf_we = (op == OP_LOAD);
          pc_d      = pc_inc;
          state_d   = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_ctrl_seq                                                  |
// | Purpose : Self-checking bench for ctrl_seq: per-cycle expected output  |
// |           table for a full program, plus reset/start corner sequences. |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  localparam int PC_W = 10;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  ctrl_seq_if #(.PC_W(PC_W)) bus();

  ctrl_seq #(
    .PC_W     (PC_W),
    .START_PC ('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: data appears one cycle after the address
  logic [8:0] imem [0:(1<<PC_W)-1];
  always @(posedge clk) bus.imem_rdata <= imem[bus.imem_addr];

  int n_checks = 0;
  int n_err    = 0;

  // Packed observation:
  // {busy, done, imem_addr[9:0], rf_we, rf_wsel, rf_wa, alu_cmd, ra_a, ra_b, dmem_req, dmem_we}
  typedef struct {
    logic        start;
    logic        zero;
    logic        ack;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [27:0] pk(input logic b, input logic d, input logic [9:0] a,
                                     input logic we, input logic ws, input logic [2:0] wa,
                                     input logic [2:0] cmd, input logic [2:0] ra,
                                     input logic [2:0] rb, input logic rq, input logic dw);
    return {b, d, a, we, ws, wa, cmd, ra, rb, rq, dw};
  endfunction

  function automatic logic [27:0] obs();
    return {busy, done, bus.imem_addr, bus.rf_we, bus.rf_wsel, bus.rf_wa, bus.alu_cmd,
            bus.rf_ra_a, bus.rf_ra_b, bus.dmem_req, bus.dmem_we};
  endfunction

  task automatic check(input string nm, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %07h expected %07h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  // FETCH and DECODE cycles of the instruction at pc
  task automatic fd(input logic [9:0] pc);
    vecs.push_back('{1'b0, 1'b0, 1'b0, pk(1, 0, pc, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, pk(1, 0, pc, 0, 0, 0, 0, 0, 0, 0, 0)});
  endtask

  task automatic ex(input logic st, input logic z, input logic [9:0] pc, input logic dn,
                    input logic we, input logic [2:0] wa, input logic [2:0] cmd,
                    input logic [2:0] ra, input logic [2:0] rb);
    vecs.push_back('{st, z, 1'b0, pk(1, dn, pc, we, 0, wa, cmd, ra, rb, 0, 0)});
  endtask

  task automatic mm(input logic ack, input logic [9:0] pc, input logic we, input logic ws,
                    input logic [2:0] wa, input logic [2:0] cmd, input logic [2:0] ra,
                    input logic [2:0] rb, input logic dw);
    vecs.push_back('{1'b0, 1'b0, ack, pk(1, 0, pc, we, ws, wa, cmd, ra, rb, 1, dw)});
  endtask

  task automatic idle_row(input logic [9:0] pc);
    vecs.push_back('{1'b0, 1'b0, 1'b0, pk(0, 0, pc, 0, 0, 0, 0, 0, 0, 0, 0)});
  endtask

  initial begin
    for (int i = 0; i < (1 << PC_W); i++) imem[i] = HALT_INSTR;
    imem[10'h000] = 9'b000_001_010;  // add   r1, r2
    imem[10'h001] = 9'b011_011_010;  // beq   r3, lut[2]
    imem[10'h020] = 9'b011_011_010;  // beq   r3, lut[2]
    imem[10'h021] = 9'b101_100_101;  // load  r4, [r5]
    imem[10'h022] = 9'b110_110_111;  // store r6, [r7]
    imem[10'h023] = 9'b011_000_111;  // beq   r0, lut[7]=0x3FF
    imem[10'h3FF] = 9'b001_010_101;  // and   r2, r5  (PC wraps after)
    imem[10'h002] = 9'b010_010_011;  // xor   r2, r3
    imem[10'h003] = 9'b100_101_110;  // move  r5, r6
    imem[10'h004] = 9'b111_111_001;  // rtl   r7, r1
    imem[10'h005] = 9'h1FF;          // HALT

    // Expected per-cycle behaviour of the program above
    fd(10'h000); ex(1, 0, 10'h000, 0, 1, 1, 0, 1, 2);  // start while busy: ignored
    fd(10'h001); ex(0, 1, 10'h001, 0, 0, 3, 3, 3, 0);  // taken -> 0x020
    fd(10'h020); ex(0, 0, 10'h020, 0, 0, 3, 3, 3, 0);  // not taken -> 0x021
    fd(10'h021); ex(0, 0, 10'h021, 0, 0, 4, 5, 4, 5);
    mm(0, 10'h021, 0, 1, 4, 5, 4, 5, 0);
    mm(0, 10'h021, 0, 1, 4, 5, 4, 5, 0);
    mm(0, 10'h021, 0, 1, 4, 5, 4, 5, 0);
    mm(1, 10'h021, 1, 1, 4, 5, 4, 5, 0);               // load writes on ack cycle
    fd(10'h022); ex(0, 0, 10'h022, 0, 0, 6, 6, 6, 7);
    mm(1, 10'h022, 0, 0, 6, 6, 6, 7, 1);               // store acked immediately
    fd(10'h023); ex(0, 1, 10'h023, 0, 0, 0, 3, 0, 0);  // taken -> 0x3FF
    fd(10'h3FF); ex(0, 0, 10'h3FF, 0, 1, 2, 1, 2, 5);  // wraps to 0x000
    fd(10'h000); ex(0, 0, 10'h000, 0, 1, 1, 0, 1, 2);
    fd(10'h001); ex(0, 0, 10'h001, 0, 0, 3, 3, 3, 0);
    fd(10'h002); ex(0, 0, 10'h002, 0, 1, 2, 2, 2, 3);
    fd(10'h003); ex(0, 0, 10'h003, 0, 1, 5, 4, 5, 6);
    fd(10'h004); ex(0, 0, 10'h004, 0, 1, 7, 7, 7, 1);
    fd(10'h005); ex(0, 0, 10'h005, 1, 0, 7, 7, 7, 7);  // HALT: done pulse
    idle_row(10'h005);
    idle_row(10'h005);

    reset        = 1'b1;
    start        = 1'b0;
    bus.alu_zero = 1'b0;
    bus.dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      start        = vecs[i].start;
      bus.alu_zero = vecs[i].zero;
      bus.dmem_ack = vecs[i].ack;
      #1;
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
      @(negedge clk);
    end
    start        = 1'b0;
    bus.alu_zero = 1'b0;
    bus.dmem_ack = 1'b0;

    // Reset and start in the same cycle: reset wins
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    #1;
    check1("rst_beats_start_busy", busy, 1'b0);
    check("rst_beats_start_pc", {18'd0, bus.imem_addr}, 28'h0000000);

    // Reset while a store is waiting in MEM
    imem[10'h000] = 9'b011_000_100;  // beq r0, lut[4]=0x080
    imem[10'h080] = 9'b110_110_111;  // store r6, [r7]
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);                  // FETCH 0x000
    start = 1'b0;
    @(negedge clk);                  // DECODE
    @(negedge clk);                  // EXEC
    bus.alu_zero = 1'b1;
    @(negedge clk);                  // FETCH 0x080
    bus.alu_zero = 1'b0;
    #1;
    check("beq_lut4_target", obs(), pk(1, 0, 10'h080, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);                  // DECODE
    @(negedge clk);                  // EXEC
    @(negedge clk);                  // MEM, no ack
    #1;
    check("store_mem_wait", obs(), pk(1, 0, 10'h080, 0, 0, 6, 6, 6, 7, 1, 1));
    @(negedge clk);                  // still waiting
    #1;
    check("store_mem_hold", obs(), pk(1, 0, 10'h080, 0, 0, 6, 6, 6, 7, 1, 1));
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_mem", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // Ack arriving after reset is ignored; a fresh start begins at START_PC
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    #1;
    check("ack_in_idle", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.dmem_ack = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("restart_fetch", obs(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
